// File: rtl/btn_toggle_debouncer.sv
// Pushbutton conditioner: two-flop synchronizer, stability-counter debounce FSM,
// one-cycle press/release strobes, a debounced level and a press-toggled state.
module btn_toggle_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter logic        PRESSED_LEVEL   = 1'b0
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic toggleBtn,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle_state
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
    localparam logic [1:0] ST_PRESSED    = 2'd2;
    localparam logic [1:0] ST_REL_WAIT   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             p_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             toggle_q, toggle_d;

    // Synchronizer preloads to the released level so a held button at reset is not an instant event
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= ~PRESSED_LEVEL;
            s2_q <= ~PRESSED_LEVEL;
        end else begin
            s1_q <= toggleBtn;
            s2_q <= s1_q;
        end
    end

    assign p_s = (s2_q == PRESSED_LEVEL);

    // Debounce FSM: a WAIT state commits only after DEBOUNCE_CYCLES agreeing samples
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
        case (state_q)
            ST_IDLE: begin
                if (p_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRESS_WAIT: begin
                if (!p_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_PRESSED;
                    cnt_d    = CNT_ZERO;
                    press_d  = 1'b1;
                    toggle_d = ~toggle_q;
                    level_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!p_s) begin
                    state_d = ST_REL_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_REL_WAIT: begin
                if (p_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = CNT_ZERO;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered outputs
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign toggle_state  = toggle_q;

endmodule

// File: tb/tb_btn_toggle_debouncer.sv
// Scoreboard bench for btn_toggle_debouncer with DEBOUNCE_CYCLES=4: stimulus queues
// expected strobes (kind, edge number, toggle value); a negedge monitor checks them.
module tb_btn_toggle_debouncer;

    localparam int N   = 4;
    localparam int LAT = N + 2;

    logic clk;
    logic reset_n;
    logic toggle_btn;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic toggle_state;

    typedef struct {
        bit is_press;
        int cyc;
        bit tog;
    } ev_t;

    ev_t exp_q[$];
    int  tests;
    int  fails;
    int  edge_n;
    bit  exp_tog;
    bit  exp_level;

    btn_toggle_debouncer #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W(3),
        .PRESSED_LEVEL(1'b0)
    ) dut (
        .CLOCK_50(clk),
        .reset_n(reset_n),
        .toggleBtn(toggle_btn),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .toggle_state(toggle_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int req);
        tests = tests + 1;
        if (act != req) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic push_ev(input bit is_press, input int cyc, input bit tog);
        ev_t e;
        e.is_press = is_press;
        e.cyc      = cyc;
        e.tog      = tog;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one pin level at a negedge; the next edge is its capture edge
    task automatic drive(input bit v);
        @(negedge clk);
        toggle_btn = v;
    endtask

    task automatic do_press();
        drive(1'b0);
        exp_tog   = ~exp_tog;
        exp_level = 1'b1;
        push_ev(1'b1, edge_n + LAT, exp_tog);
        wait_cycles(10);
        check("level_after_press", int'(btn_level), int'(exp_level));
    endtask

    task automatic do_release();
        drive(1'b1);
        exp_level = 1'b0;
        push_ev(1'b0, edge_n + LAT, exp_tog);
        wait_cycles(10);
        check("level_after_release", int'(btn_level), int'(exp_level));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_btn_level"}, int'(btn_level), 0);
        check({tag, "_press"}, int'(press_pulse), 0);
        check({tag, "_release"}, int'(release_pulse), 0);
        check({tag, "_toggle"}, int'(toggle_state), 0);
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (reset_n && (press_pulse || release_pulse)) begin
            if (press_pulse && release_pulse) begin
                check("both_pulses", 1, 0);
            end
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_press", int'(press_pulse), 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("pulse_kind_press", int'(press_pulse), int'(e.is_press));
                check("pulse_edge", edge_n, e.cyc);
                check("pulse_toggle", int'(toggle_state), int'(e.tog));
                check("pulse_level", int'(btn_level), int'(e.is_press));
            end
        end
    end

    initial begin
        int e0;
        tests      = 0;
        fails      = 0;
        edge_n     = 0;
        exp_tog    = 1'b0;
        exp_level  = 1'b0;
        toggle_btn = 1'b0;
        reset_n    = 1'b0;

        // Reset held with button pressed
        wait_cycles(5);
        check_reset_outputs("rst_hold");
        reset_n = 1'b1;
        e0      = edge_n;
        exp_tog = 1'b1;
        exp_level = 1'b1;
        push_ev(1'b1, e0 + LAT, 1'b1);
        wait_cycles(10);
        check("level_after_reset_press", int'(btn_level), 1);
        do_release();

        // Clean press, a 3-sample release glitch that must be ignored, then a real release
        do_press();
        drive(1'b1); drive(1'b1); drive(1'b1); drive(1'b0);
        wait_cycles(10);
        check("level_after_rel_glitch", int'(btn_level), 1);
        do_release();

        // Bounce: 3-sample pressed runs never qualify
        for (int r = 0; r < 3; r++) begin
            drive(1'b0); drive(1'b0); drive(1'b0); drive(1'b1);
        end
        wait_cycles(3);
        check("level_after_bounce", int'(btn_level), 0);
        do_press();
        do_release();

        // Three clean press/release pairs
        for (int i = 0; i < 3; i++) begin
            do_press();
            do_release();
        end

        // Reset while counting a press (cnt reaches 2 after the fourth edge)
        drive(1'b0);
        wait_cycles(4);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_midcount");
        wait_cycles(3);
        check_reset_outputs("rst_midcount_hold");
        reset_n   = 1'b1;
        e0        = edge_n;
        exp_tog   = 1'b1;
        exp_level = 1'b1;
        push_ev(1'b1, e0 + LAT, 1'b1);
        wait_cycles(10);
        check("level_after_midcount", int'(btn_level), 1);
        do_release();

        wait_cycles(5);
        check("events_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
